// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and pulse-condition a push button
//
// Purpose:
//   Turns a raw, bouncing, asynchronous push-button input into clean clk-domain
//   signals: a debounced level, one-cycle press/release pulses, and an
//   auto-repeat pulse train while the button is held.
//
// Ports:
//   clk            in   rising-edge clock for all state
//   rst            in   asynchronous active-high reset
//   btn_in         in   raw button, asynchronous, may bounce
//   en             in   synchronous enable; 0 forces IDLE and clears counters/outputs
//   btn_level      out  debounced level (1 in PRESSED and RELEASE_WAIT)
//   press_pulse    out  one-cycle pulse on an accepted press
//   release_pulse  out  one-cycle pulse on an accepted release
//   repeat_pulse   out  one-cycle pulse per auto-repeat tick
//   held           out  1 once the hold reached REPEAT_DELAY, until the release is accepted

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_VALUE  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  // Phase within the repeat period; keeps the cadence going after rcnt saturates.
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic btn_level_q, btn_level_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;
  logic repeat_pulse_q, repeat_pulse_d;
  logic held_q, held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      rcnt_q          <= '0;
      pcnt_q          <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      held_q          <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rcnt_q          <= rcnt_d;
      pcnt_q          <= pcnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      held_q          <= held_d;
    end
  end

  always_comb begin
    // The synchroniser runs regardless of en; the FSM only ever looks at s2.
    s1_d            = btn_in;
    s2_d            = s1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    rcnt_d          = rcnt_q;
    pcnt_d          = pcnt_q;
    held_d          = held_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    repeat_pulse_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      rcnt_d  = '0;
      pcnt_d  = '0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s2_q) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end

        PRESS_WAIT: begin
          // The s2 test comes first so a bounce on the completing edge aborts.
          if (!s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d       = PRESSED;
            cnt_d         = '0;
            rcnt_d        = '0;
            pcnt_d        = '0;
            held_d        = 1'b0;
            press_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        PRESSED: begin
          if (!s2_q) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            if (rcnt_q != CNT_MAX) begin
              rcnt_d = rcnt_q + 1'b1;
            end
            if (REPEAT_EN) begin
              if (!held_q) begin
                if (rcnt_d == RD_VALUE) begin
                  held_d         = 1'b1;
                  repeat_pulse_d = 1'b1;
                  pcnt_d         = '0;
                end
              end else if (pcnt_q == RP_LAST) begin
                repeat_pulse_d = 1'b1;
                pcnt_d         = '0;
              end else begin
                pcnt_d = pcnt_q + 1'b1;
              end
            end
          end
        end

        RELEASE_WAIT: begin
          // A return to 1 is a glitch: go back to PRESSED with rcnt/pcnt/held intact.
          if (s2_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d         = IDLE;
            cnt_d           = '0;
            rcnt_d          = '0;
            pcnt_d          = '0;
            held_d          = 1'b0;
            release_pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - bench for button_conditioner

module tb_button_conditioner;

  localparam int D = 4;
  localparam int R = 8;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic en = 1'b1;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, held;

  int total = 0;
  int bad = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(R),
    .REPEAT_PERIOD(P),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .en(en),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: accepted level flips once the FSM has seen D consecutive
  // synchronised samples opposite to it; hold length counts the sampled-high
  // cycles spent in the pressed state (not during a rejected release glitch).
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
  logic m_press = 1'b0, m_rel = 1'b0, m_rep = 1'b0;
  int m_run = 0, m_hold = 0;
  logic m_held;

  assign m_held = (R > 0) && m_level && (m_hold >= R);

  always @(posedge clk or posedge rst) begin : model
    int run_n, hold_n;
    logic lvl_n, pr, rl, rp;
    if (rst) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
      m_run <= 0; m_hold <= 0;
      m_press <= 1'b0; m_rel <= 1'b0; m_rep <= 1'b0;
    end else begin
      lvl_n = m_level; run_n = m_run; hold_n = m_hold;
      pr = 1'b0; rl = 1'b0; rp = 1'b0;
      if (!en) begin
        lvl_n = 1'b0; run_n = 0; hold_n = 0;
      end else if (!m_level) begin
        if (m_s2) begin
          run_n = m_run + 1;
          if (run_n == D) begin
            lvl_n = 1'b1; run_n = 0; hold_n = 0; pr = 1'b1;
          end
        end else begin
          run_n = 0;
        end
      end else begin
        if (!m_s2) begin
          run_n = m_run + 1;
          if (run_n == D) begin
            lvl_n = 1'b0; run_n = 0; hold_n = 0; rl = 1'b1;
          end
        end else if (m_run > 0) begin
          run_n = 0;
        end else begin
          hold_n = m_hold + 1;
          if (R > 0 && hold_n >= R && ((hold_n - R) % P) == 0) rp = 1'b1;
        end
      end
      m_s1 <= btn_in;
      m_s2 <= m_s1;
      m_level <= lvl_n; m_run <= run_n; m_hold <= hold_n;
      m_press <= pr; m_rel <= rl; m_rep <= rp;
    end
  end

  always @(negedge clk) begin
    chk("level", btn_level, m_level);
    chk("press", press_pulse, m_press);
    chk("release", release_pulse, m_rel);
    chk("repeat", repeat_pulse, m_rep);
    chk("held", held, m_held);
  end

  initial begin : stim
    int pc, first, rc, lowc, rpc;
    #1 rst = 1'b1;
    nclk(3);
    rst = 1'b0;
    nclk(2);
    chk("reset_level", btn_level, 0);
    chk("reset_held", held, 0);

    // Clean press, repeat cadence, release.
    btn_in = 1'b1;
    nclk(5);
    chk("press_e4", press_pulse, 0);
    nclk(1);
    chk("press_e5", press_pulse, 1);
    chk("level_e5", btn_level, 1);
    nclk(7);
    chk("rep_e12", repeat_pulse, 0);
    chk("held_e12", held, 0);
    nclk(1);
    chk("rep_e13", repeat_pulse, 1);
    chk("held_e13", held, 1);
    nclk(2);
    chk("rep_e15", repeat_pulse, 0);
    nclk(1);
    chk("rep_e16", repeat_pulse, 1);
    nclk(14);
    btn_in = 1'b0;
    nclk(5);
    chk("rel_e4", release_pulse, 0);
    chk("rel_level_e4", btn_level, 1);
    nclk(1);
    chk("rel_e5", release_pulse, 1);
    chk("rel_level_e5", btn_level, 0);
    nclk(1);
    chk("rel_e6", release_pulse, 0);
    nclk(3);

    // Bounce: 1,1,0 then steady 1.
    btn_in = 1'b1;
    nclk(2);
    btn_in = 1'b0;
    nclk(1);
    btn_in = 1'b1;
    pc = 0; first = -1;
    for (int i = 0; i < 15; i++) begin
      nclk(1);
      if (press_pulse) begin
        pc++;
        if (first < 0) first = i;
      end
    end
    chk("bounce_count", pc, 1);
    chk("bounce_index", first, 5);
    btn_in = 1'b0;
    nclk(10);

    // Release glitch inside PRESSED after held.
    btn_in = 1'b1;
    nclk(16);
    btn_in = 1'b0;
    nclk(2);
    btn_in = 1'b1;
    rc = 0; lowc = 0; rpc = 0;
    for (int i = 0; i < 20; i++) begin
      nclk(1);
      rc += int'(release_pulse);
      lowc += int'(!btn_level);
      rpc += int'(repeat_pulse);
    end
    chk("glitch_release", rc, 0);
    chk("glitch_low", lowc, 0);
    chk("glitch_repeats", rpc, 6);
    btn_in = 1'b0;
    nclk(10);

    // Enable drop while pressed.
    btn_in = 1'b1;
    nclk(8);
    en = 1'b0;
    nclk(1);
    chk("en_level", btn_level, 0);
    rc = 0;
    for (int i = 0; i < 5; i++) begin
      nclk(1);
      rc += int'(release_pulse);
    end
    chk("en_release", rc, 0);
    en = 1'b1;
    nclk(3);
    chk("en_press_e2", press_pulse, 0);
    nclk(1);
    chk("en_press_e3", press_pulse, 1);
    nclk(3);

    // Asynchronous reset mid-PRESSED with the button still held.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_level", btn_level, 0);
    chk("rst_async_held", held, 0);
    nclk(2);
    rst = 1'b0;
    nclk(5);
    chk("rst_press_e4", press_pulse, 0);
    nclk(1);
    chk("rst_press_e5", press_pulse, 1);
    btn_in = 1'b0;
    nclk(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
